// File: rtl/sys_out_collector.sv
// rtl/sys_out_collector.sv - de-skews 2x2 systolic column outputs into rows and writes them to the unified buffer
module sys_out_collector #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  input  logic [ADDR_W-1:0]     cfg_base_addr,
  input  logic [15:0]           cfg_rows,
  input  logic [1:0]            cfg_cols,
  input  logic [DATA_W-1:0]     col_data_1,
  input  logic                  col_valid_1,
  input  logic [DATA_W-1:0]     col_data_2,
  input  logic                  col_valid_2,
  output logic                  wr_valid,
  input  logic                  wr_ready,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [2*DATA_W-1:0]   wr_data,
  output logic [1:0]            wr_mask,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic                  skew_err
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DRAIN   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t              state;

  // Job configuration latched on cfg_valid in IDLE
  logic [ADDR_W-1:0]   base_addr;
  logic [15:0]         rows_cfg;
  logic                cols_one;

  // Column-1 delay stage that lines it up with column 2
  logic [DATA_W-1:0]   d1_data;
  logic                d1_valid;

  // Row FIFO
  logic [2*DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [1:0]          fifo_mask [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    count;

  // Row accounting
  logic [15:0]         rows_pushed;
  logic [15:0]         rows_dropped;
  logic [ADDR_W-1:0]   write_index;

  // Combinational row assembly and FIFO control
  logic                in_collect;
  logic                fifo_empty;
  logic                fifo_full;
  logic                row_complete;
  logic                row_partial;
  logic                pop;
  logic                push;
  logic                drop_full;
  logic                row_drop;
  logic [CNT_W-1:0]    count_next;
  logic [15:0]         pushed_next;
  logic [15:0]         dropped_next;
  logic [16:0]         accounted_next;
  logic                all_accounted;
  logic [2*DATA_W-1:0] row_data;
  logic [1:0]          row_mask;

  // Decide row completion, push/pop/drop and next-cycle counts
  always_comb begin
    in_collect     = (state == S_COLLECT);
    fifo_empty     = (count == '0);
    fifo_full      = (count == CNT_W'(FIFO_DEPTH));
    // A full row: column 1 from the delay stage plus column 2 this cycle
    row_complete   = in_collect && d1_valid && (cols_one || col_valid_2);
    // Two-column mode with only one half present is a misaligned fragment
    row_partial    = in_collect && !cols_one && (d1_valid ^ col_valid_2);
    pop            = !fifo_empty && wr_ready;
    // A simultaneous pop frees the slot, so a full FIFO still accepts
    push           = row_complete && (!fifo_full || pop);
    drop_full      = row_complete && fifo_full && !pop;
    row_drop       = drop_full || row_partial;
    count_next     = count + CNT_W'(push) - CNT_W'(pop);
    pushed_next    = rows_pushed + 16'(push);
    dropped_next   = rows_dropped + 16'(row_drop);
    accounted_next = {1'b0, pushed_next} + {1'b0, dropped_next};
    all_accounted  = (accounted_next == {1'b0, rows_cfg});
    row_data       = {(cols_one ? {DATA_W{1'b0}} : col_data_2), d1_data};
    row_mask       = cols_one ? 2'b01 : 2'b11;
  end

  // FIFO storage; contents need no reset because reads are gated by the count
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= row_data;
      fifo_mask[wr_ptr] <= row_mask;
    end
  end

  // Column-1 delay register, only loaded while collecting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d1_data  <= '0;
      d1_valid <= 1'b0;
    end else begin
      d1_valid <= in_collect && col_valid_1;
      if (in_collect && col_valid_1) begin
        d1_data <= col_data_1;
      end
    end
  end

  // FIFO pointers and write index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      write_index <= '0;
    end else begin
      count <= count_next;
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr      <= rd_ptr + PTR_W'(1);
        write_index <= write_index + ADDR_W'(1);
      end else if (state == S_IDLE && cfg_valid) begin
        write_index <= '0;
      end
    end
  end

  // Job FSM: config capture, row accounting, sticky flags and the done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      base_addr    <= '0;
      rows_cfg     <= '0;
      cols_one     <= 1'b0;
      rows_pushed  <= '0;
      rows_dropped <= '0;
      done         <= 1'b0;
      overflow     <= 1'b0;
      skew_err     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (cfg_valid) begin
            base_addr    <= cfg_base_addr;
            rows_cfg     <= cfg_rows;
            cols_one     <= (cfg_cols == 2'd1);
            rows_pushed  <= '0;
            rows_dropped <= '0;
            overflow     <= 1'b0;
            skew_err     <= 1'b0;
            state        <= (cfg_rows == 16'd0) ? S_DONE : S_COLLECT;
          end
        end
        S_COLLECT: begin
          rows_pushed  <= pushed_next;
          rows_dropped <= dropped_next;
          if (row_partial) skew_err <= 1'b1;
          if (drop_full)   overflow <= 1'b1;
          if (all_accounted) begin
            // Finish straight away when nothing is left to write
            if (count_next == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (count_next == '0) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          // Arriving from a zero-row config the pulse is raised here first
          if (done) begin
            done  <= 1'b0;
            state <= S_IDLE;
          end else begin
            done <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // Write port driven from the FIFO head; zero whenever nothing is queued
  always_comb begin
    wr_valid = !fifo_empty;
    wr_data  = fifo_empty ? '0 : fifo_data[rd_ptr];
    wr_mask  = fifo_empty ? 2'b00 : fifo_mask[rd_ptr];
    wr_addr  = base_addr + write_index;
    busy     = (state == S_COLLECT) || (state == S_DRAIN);
  end

endmodule

// File: doc/sys_out_collector.md
Name: sys_out_collector

Overview:
- Receive-side companion to the 2x2 systolic array: captures the skewed, bottom-edge psum outputs of both columns.
- De-skews them into whole result rows and buffers rows in a small FIFO.
- Writes each row to the unified buffer over a valid/ready write port at consecutive addresses.
- Tracks row count and signals completion to the controller.

Parameters:
- DATA_W, 32, width of one column result (signed).
- FIFO_DEPTH, 4, number of row entries buffered (power of two, >=2).
- ADDR_W, 16, unified-buffer write address width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- cfg_valid  in  1  one-cycle pulse that loads the job config; honoured only in IDLE.
- cfg_base_addr  in  ADDR_W  address of the first result row.
- cfg_rows  in  16  number of rows to write.
- cfg_cols  in  2  active columns; legal values 1 or 2, others treated as 2.
- col_data_1  in  DATA_W  column-1 result (array bottom-left).
- col_valid_1  in  1  column-1 result valid.
- col_data_2  in  DATA_W  column-2 result (array bottom-right).
- col_valid_2  in  1  column-2 result valid.
- wr_valid  out  1  write request.
- wr_ready  in  1  unified buffer accepts the write.
- wr_addr  out  ADDR_W  write address.
- wr_data  out  2*DATA_W  {col2, col1}; col1 in the low half.
- wr_mask  out  2  per-column write enable; bit0 = col1.
- busy  out  1  high in COLLECT and DRAIN.
- done  out  1  one-cycle pulse when the last row is written.
- overflow  out  1  sticky: a row was dropped because the FIFO was full.
- skew_err  out  1  sticky: column valids were misaligned.

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk.
  - All outputs go to 0 and state goes to IDLE.
  - FIFO pointers, row counters, the skew register and the sticky flags clear.
  - Reset mid-job abandons the job; no write occurs after reset is released until a new cfg_valid.
- States:
  - IDLE: cfg_valid latches base, rows and cols, clears overflow and skew_err, and goes to COLLECT. If cfg_rows==0, go to DONE instead.
  - COLLECT: assemble and push rows. When rows_pushed+rows_dropped==cfg_rows, go to DRAIN.
  - DRAIN: no further pushes; column inputs are ignored. When FIFO is empty and all pushed rows are written, go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- cfg_valid outside IDLE is ignored. Column inputs in IDLE/DONE are ignored.
- De-skew:
  - Column 2 lags column 1 by one cycle for the same row.
  - col_data_1/col_valid_1 are registered once (d1_data, d1_valid).
- Row completion in cycle t, COLLECT only:
  - cols==2: complete when d1_valid && col_valid_2; mask=2'b11.
  - cols==1: complete when d1_valid; mask=2'b01; col2 half zero; col_valid_2 ignored.
  - cols==2 with exactly one of d1_valid/col_valid_2 high: set skew_err, discard the partial row, and count it as dropped.
- Push: a completed row is pushed at the clock edge ending cycle t. wr_valid is high from cycle t+1 (one-cycle latency from col2 valid to wr_valid).
- FIFO:
  - wr_valid = !empty; wr_data/wr_mask come from the head entry.
  - Pop on wr_valid && wr_ready.
  - wr_addr = cfg_base_addr + write_index; write_index increments per accepted write and wraps modulo 2^ADDR_W.
  - Output fields hold stable while wr_valid && !wr_ready.
  - Push when full with a simultaneous pop: accepted, no overflow.
  - Push when full without a pop: row dropped, overflow set, row counts as dropped.
  - Push and pop on the same cycle keep the count unchanged.
- Counters are 16-bit; cfg_rows up to 65535.
- done asserts in the cycle after the final accepted write, or the final drop if nothing remains.

Test Plan:
- Basic: cfg rows=2, cols=2, base=0x10; col1 = 5 then -3 (cycles 0,1); col2 = 7 then 9 (cycles 1,2); wr_ready=1 -> writes {7,5}@0x10 then {9,-3}@0x11, mask=11, done pulse once, busy low afterwards.
- Single column: rows=3, cols=1, col1 = 1,2,3 back-to-back, col_valid_2 toggling -> three writes, mask=01, high half 0, addresses base..base+2, skew_err=0.
- Backpressure: rows=6, cols=2, wr_ready=0 throughout the stream -> 4 rows buffered, 2 dropped, overflow=1. Then wr_ready=1 -> 4 writes with stable data while stalled, then done.
- Skew: cols=2, col_valid_2 asserted the same cycle as col_valid_1 -> skew_err=1, partial rows discarded and counted; done still asserts.
- Zero rows: cfg rows=0 -> done high exactly 2 cycles after cfg_valid, no wr_valid.
- Reset mid-job: assert rst after 1 of 3 rows written -> all outputs 0 immediately; no writes after release. A new cfg then behaves as the basic test.
